// File: rtl/sine_sweep_sequencer.sv
// Frequency-sweep scheduler: steps the NCO tuning word from start toward stop with a programmable dwell.
// Define SWEEP_PINGPONG_EN to make mode 2 a ping-pong sweep; otherwise mode 2 runs as continuous.
module sine_sweep_sequencer #(
  parameter int TW_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic [1:0]      mode,
  input  logic            start,
  input  logic            abort,
  output logic [TW_W-1:0] tune_word,
  output logic            tune_upd,
  output logic            phase_clr,
  output logic            busy,
  output logic            done,
  output logic            sweep_dir
);

  // The STEP decision is folded into the last DWELL cycle, so it needs no state of its own.
  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;
  typedef enum logic [1:0] {M_SINGLE, M_CONT, M_PP} sweep_mode_t;

  logic [15:0]     reg_start, reg_stop, reg_step, reg_dwell;
  logic [TW_W-1:0] sh_start, sh_stop, sh_step;
  logic [15:0]     sh_dwell;
  sweep_mode_t     sh_mode;
  sweep_mode_t     start_mode;
  state_t          state;
  logic [15:0]     cnt;

  logic [TW_W:0]   asc_sum;
  logic [TW_W-1:0] asc_word;
  logic            at_stop;
  logic            dwell_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_start <= '0;
      reg_stop  <= '0;
      reg_step  <= '0;
      reg_dwell <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0: reg_start[7:0]  <= cfg_data;
        3'd1: reg_start[15:8] <= cfg_data;
        3'd2: reg_stop[7:0]   <= cfg_data;
        3'd3: reg_stop[15:8]  <= cfg_data;
        3'd4: reg_step[7:0]   <= cfg_data;
        3'd5: reg_step[15:8]  <= cfg_data;
        3'd6: reg_dwell[7:0]  <= cfg_data;
        default: reg_dwell[15:8] <= cfg_data;
      endcase
    end
  end

  always_comb begin
    start_mode = M_SINGLE;
    case (mode)
      2'd1: start_mode = M_CONT;
`ifdef SWEEP_PINGPONG_EN
      2'd2: start_mode = M_PP;
`else
      2'd2: start_mode = M_CONT;
`endif
      default: start_mode = M_SINGLE;
    endcase
  end

  // A zero step counts as "endpoint reached" so the start word is never re-issued unchanged.
  assign asc_sum   = {1'b0, tune_word} + {1'b0, sh_step};
  assign at_stop   = (tune_word >= sh_stop) || (sh_step == '0);
  assign asc_word  = (asc_sum >= {1'b0, sh_stop}) ? sh_stop : asc_sum[TW_W-1:0];
  assign dwell_end = (cnt == ((sh_dwell == 16'd0) ? 16'd1 : sh_dwell));

`ifdef SWEEP_PINGPONG_EN
  logic [TW_W:0]   desc_diff;
  logic [TW_W-1:0] desc_word;
  logic            at_start;

  assign desc_diff = {1'b0, tune_word} - {1'b0, sh_step};
  assign at_start  = (tune_word <= sh_start);
  assign desc_word = (desc_diff[TW_W] || (desc_diff[TW_W-1:0] <= sh_start)) ?
                     sh_start : desc_diff[TW_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_mode   <= M_SINGLE;
      cnt       <= '0;
      tune_word <= '0;
      tune_upd  <= 1'b0;
      phase_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sweep_dir <= 1'b0;
    end else begin
      tune_upd  <= 1'b0;
      phase_clr <= 1'b0;
      done      <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              sh_start <= reg_start[TW_W-1:0];
              sh_stop  <= reg_stop[TW_W-1:0];
              sh_step  <= reg_step[TW_W-1:0];
              sh_dwell <= reg_dwell;
              sh_mode  <= start_mode;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            tune_word <= sh_start;
            tune_upd  <= 1'b1;
            phase_clr <= 1'b1;
            sweep_dir <= 1'b0;
            cnt       <= 16'd1;
            state     <= DWELL;
          end
          default: begin
            if (!dwell_end) begin
              cnt <= cnt + 16'd1;
            end else begin
              cnt <= 16'd1;
`ifdef SWEEP_PINGPONG_EN
              if (sweep_dir) begin
                if (at_start) begin
                  sweep_dir <= 1'b0;
                end else begin
                  tune_word <= desc_word;
                  tune_upd  <= 1'b1;
                end
              end else
`endif
              if (!at_stop) begin
                tune_word <= asc_word;
                tune_upd  <= 1'b1;
              end else begin
                case (sh_mode)
                  M_CONT: begin
                    tune_word <= sh_start;
                    tune_upd  <= 1'b1;
                    phase_clr <= 1'b1;
                  end
`ifdef SWEEP_PINGPONG_EN
                  // Degenerate sweeps sit on start, so only the direction flag toggles.
                  M_PP: begin
                    sweep_dir <= 1'b1;
                    if (!at_start) begin
                      tune_word <= desc_word;
                      tune_upd  <= 1'b1;
                    end
                  end
`endif
                  default: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sine_sweep_sequencer.sv
// Scoreboard bench for sine_sweep_sequencer: stimulus queues expected word/done events, a monitor pops them.
module tb_sine_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [1:0]  mode;
  logic        start;
  logic        abort;
  logic [15:0] tune_word;
  logic        tune_upd;
  logic        phase_clr;
  logic        busy;
  logic        done;
  logic        sweep_dir;

  typedef struct {
    bit          is_done;
    logic [15:0] word;
    bit          pclr;
    bit          dir;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_upd    = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   upd_before;

  sine_sweep_sequencer #(.TW_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .mode(mode), .start(start), .abort(abort), .tune_word(tune_word), .tune_upd(tune_upd),
    .phase_clr(phase_clr), .busy(busy), .done(done), .sweep_dir(sweep_dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expUpd(input logic [15:0] word, input bit pclr, input bit dir, input int gap);
    exp_t x;
    x.is_done = 1'b0;
    x.word    = word;
    x.pclr    = pclr;
    x.dir     = dir;
    x.gap     = gap;
    exp_q.push_back(x);
  endtask

  task automatic expDone(input int gap);
    exp_t x;
    x.is_done = 1'b1;
    x.word    = '0;
    x.pclr    = 1'b0;
    x.dir     = 1'b0;
    x.gap     = gap;
    exp_q.push_back(x);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic pulseStart(input logic [1:0] m, input logic ab);
    mode  = m;
    start = 1'b1;
    abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] s_start, input logic [15:0] s_stop,
                               input logic [15:0] s_step, input logic [15:0] s_dwell,
                               input logic [1:0] m);
    writeReg(3'd0, s_start[7:0]);
    writeReg(3'd1, s_start[15:8]);
    writeReg(3'd2, s_stop[7:0]);
    writeReg(3'd3, s_stop[15:8]);
    writeReg(3'd4, s_step[7:0]);
    writeReg(3'd5, s_step[15:8]);
    writeReg(3'd6, s_dwell[7:0]);
    writeReg(3'd7, s_dwell[15:8]);
    pulseStart(m, 1'b0);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    #1;
  endtask

  task automatic abortNow();
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  // Every tune_upd or done pulse must match the next queued expectation, including its spacing.
  always @(negedge clk) begin
    if (!rst && (tune_upd || done)) begin
      if (tune_upd) n_upd++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {30'd0, done, tune_upd}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_is_done", {31'd0, done}, {31'd0, e.is_done});
        if (!e.is_done) begin
          checkOutput("tune_word", {16'd0, tune_word}, {16'd0, e.word});
          checkOutput("phase_clr", {31'd0, phase_clr}, {31'd0, e.pclr});
          checkOutput("sweep_dir", {31'd0, sweep_dir}, {31'd0, e.dir});
        end
        if (e.gap != 0) checkOutput("event_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    mode = '0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and a quiet idle period.
    @(negedge clk);
    checkOutput("rst_tune_word", {16'd0, tune_word}, 32'd0);
    checkOutput("rst_tune_upd", {31'd0, tune_upd}, 32'd0);
    checkOutput("rst_phase_clr", {31'd0, phase_clr}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sweep_dir", {31'd0, sweep_dir}, 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("idle_no_upd", n_upd, 32'd0);

    // Single sweep 100..130 step 10 dwell 4.
    $display("[TB] single sweep");
    expUpd(16'd100, 1, 0, 0); expUpd(16'd110, 0, 0, 4);
    expUpd(16'd120, 0, 0, 4); expUpd(16'd130, 0, 0, 4); expDone(4);
    applyStimulus(16'd100, 16'd130, 16'd10, 16'd4, 2'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("load_busy", {31'd0, busy}, 32'd1);
    checkOutput("load_tune_upd", {31'd0, tune_upd}, 32'd1);
    checkOutput("load_word", {16'd0, tune_word}, 32'd100);
    waitDrain(100);
    @(negedge clk);
    checkOutput("single_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("single_word_held", {16'd0, tune_word}, 32'd130);

    // Carry clamp to stop, then a stop-below-start sweep.
    $display("[TB] clamp and overflow");
    expUpd(16'hFFF0, 1, 0, 0); expUpd(16'hFFFF, 0, 0, 1); expDone(1);
    applyStimulus(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 2'd0);
    waitDrain(100);
    expUpd(16'd100, 1, 0, 0); expDone(1);
    applyStimulus(16'd100, 16'd90, 16'h0020, 16'd1, 2'd0);
    waitDrain(100);

    // Continuous sweep, then abort mid-dwell.
    $display("[TB] continuous");
    expUpd(16'd10, 1, 0, 0); expUpd(16'd20, 0, 0, 2); expUpd(16'd30, 0, 0, 2);
    expUpd(16'd10, 1, 0, 2); expUpd(16'd20, 0, 0, 2);
    applyStimulus(16'd10, 16'd30, 16'd10, 16'd2, 2'd1);
    waitDrain(100);
    abortNow();
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_word", {16'd0, tune_word}, 32'd20);
    repeat (6) @(negedge clk);
    checkOutput("abort_word_held", {16'd0, tune_word}, 32'd20);

    // Mode 2: ping-pong when enabled, continuous otherwise.
    $display("[TB] mode 2");
`ifdef SWEEP_PINGPONG_EN
    expUpd(16'd10, 1, 0, 0); expUpd(16'd25, 0, 0, 3); expUpd(16'd40, 0, 0, 3);
    expUpd(16'd25, 0, 1, 3); expUpd(16'd10, 0, 1, 3); expUpd(16'd25, 0, 0, 0);
`else
    expUpd(16'd10, 1, 0, 0); expUpd(16'd25, 0, 0, 3); expUpd(16'd40, 0, 0, 3);
    expUpd(16'd10, 1, 0, 3); expUpd(16'd25, 0, 0, 3);
`endif
    applyStimulus(16'd10, 16'd40, 16'd15, 16'd3, 2'd2);
    waitDrain(200);
    abortNow();
    @(negedge clk);
    checkOutput("mode2_abort_word", {16'd0, tune_word}, 32'd25);

    // Step rewrite and start while busy affect only the next sweep.
    $display("[TB] shadowing");
    expUpd(16'd100, 1, 0, 0); expUpd(16'd110, 0, 0, 4);
    expUpd(16'd120, 0, 0, 4); expUpd(16'd130, 0, 0, 4); expDone(4);
    applyStimulus(16'd100, 16'd130, 16'd10, 16'd4, 2'd0);
    writeReg(3'd4, 8'd20);
    pulseStart(2'd0, 1'b0);
    waitDrain(100);
    expUpd(16'd100, 1, 0, 0); expUpd(16'd120, 0, 0, 4); expUpd(16'd130, 0, 0, 4); expDone(4);
    pulseStart(2'd0, 1'b0);
    waitDrain(100);

    // Start together with abort in IDLE is dropped.
    upd_before = n_upd;
    pulseStart(2'd0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("start_abort_no_upd", n_upd, upd_before);

    // Reset mid-sweep clears outputs, registers and shadow.
    $display("[TB] reset mid-sweep");
    expUpd(16'd100, 1, 0, 0);
    applyStimulus(16'd100, 16'd130, 16'd10, 16'd4, 2'd0);
    waitDrain(100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_word", {16'd0, tune_word}, 32'd0);
    expUpd(16'd0, 1, 0, 0); expDone(1);
    pulseStart(2'd0, 1'b0);
    waitDrain(100);
    @(negedge clk);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sine_sweep_sequencer.md
# sine_sweep_sequencer

Frequency-sweep scheduler for the sine generator's phase-accumulator NCO. Holds a byte-writable register file (start, stop and step tuning words, dwell count), snapshots it on a start command, then steps the NCO tuning word from start toward stop. Each word is held for a programmable dwell. Sits between the TinyTapeout pin/config front end and the NCO, and is the only writer of the NCO tuning word and phase-clear.

## Interface
Parameters:
- `TW_W`, 16: tuning-word width, legal 9..16. Register bits above `TW_W` are written but ignored.

Ports:
- `clk` in 1: system clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 3: register select. 0/1 start lo/hi, 2/3 stop lo/hi, 4/5 step lo/hi, 6/7 dwell lo/hi.
- `cfg_data` in 8: write data.
- `mode` in 2: sweep mode, sampled with `start`. 0 single, 1 continuous, 2 ping-pong, 3 reserved (behaves as 0).
- `start` in 1: begin a sweep (one-cycle pulse).
- `abort` in 1: terminate the sweep.
- `tune_word` out `TW_W`: tuning word to the NCO.
- `tune_upd` out 1: one-cycle pulse on the first cycle a new `tune_word` value is presented.
- `phase_clr` out 1: one-cycle pulse that zeroes the NCO phase accumulator.
- `busy` out 1: high while a sweep is active.
- `done` out 1: one-cycle pulse when a single-mode sweep completes.
- `sweep_dir` out 1: 0 ascending, 1 descending.

## Operation
- Register file:
  - Writes take effect the cycle after `cfg_we`, in any state.
  - Active sweep parameters come from a shadow copy taken on an accepted `start`. Writes during a sweep affect only the next sweep.
- States: IDLE, LOAD, DWELL, STEP.
- IDLE:
  - `start && !abort` → LOAD.
  - Shadow ← registers; mode latched; `busy` ← 1.
- LOAD (1 cycle):
  - `tune_word` ← start word; `tune_upd` = 1; `phase_clr` = 1; `sweep_dir` ← 0.
  - Dwell counter ← 1; → DWELL.
- DWELL:
  - Counter increments each cycle.
  - When counter = `max(dwell,1)` → STEP.
- STEP (combinational decision, 0 extra cycles: the new word appears on the cycle after the last dwell cycle).
- Ascending:
  - `nxt = cur + step`, computed in `TW_W+1` bits.
  - If `cur >= stop` (endpoint already reached), apply the end action.
  - Else if `nxt >= stop` or the sum carries out, `tune_word` ← stop.
  - Else `tune_word` ← `nxt`.
- Descending (ping-pong only):
  - `nxt = cur - step`.
  - If `cur <= start`, turn around: `sweep_dir` ← 0.
  - Else if the subtraction borrows or `nxt <= start`, `tune_word` ← start.
  - Else `tune_word` ← `nxt`.
- End action at the stop endpoint:
  - Single: `busy` ← 0; `done` = 1 for one cycle; → IDLE. `tune_word` retains its last value.
  - Continuous: behave as LOAD (start word, `tune_upd`, `phase_clr`).
  - Ping-pong: `sweep_dir` ← 1, then apply the descending step immediately. No `phase_clr`.
- Every change of `tune_word` is accompanied by `tune_upd`. A word is never re-issued unchanged, except LOAD in continuous mode.
- Degenerate cases:
  - `step` = 0 or `stop <= start`: only the start word is issued. Single finishes after one dwell. Continuous reloads start (with `phase_clr`) every dwell. Ping-pong holds start, toggles `sweep_dir` each dwell, and never re-issues the word.
- `abort`, in any non-IDLE state:
  - → IDLE next cycle; `busy` ← 0; no `done`; `tune_word` retained.
  - `abort` with `start` in IDLE: abort wins, start is ignored.
- `start` while `busy` is ignored.
- `rst` mid-sweep: all state cleared in the same edge.

## Timing
- Reset values: `tune_word` 0, `tune_upd` 0, `phase_clr` 0, `busy` 0, `done` 0, `sweep_dir` 0. All registers and the shadow are 0.
- Start to LOAD output: `start` sampled at edge N; `busy`, `tune_upd`, `phase_clr` and `tune_word`=start are valid after edge N+1.
- Word period: consecutive `tune_upd` pulses are exactly `max(dwell,1)` cycles apart.
- Single sweep completion: `done` pulses exactly `max(dwell,1)` cycles after the last word's `tune_upd`. `busy` falls on that same edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SWEEP_PINGPONG_EN` defined: mode 2 is ping-pong as described, with descending arithmetic and `sweep_dir` toggling.
- `SWEEP_PINGPONG_EN` not defined: descending logic is removed, mode 2 behaves as mode 1 (continuous), and `sweep_dir` is tied to 0.

## Test plan
- Reset and idle: assert `rst` 2 cycles → all outputs 0. No `tune_upd` for 20 idle cycles.
- Single sweep: start=100, stop=130, step=10, dwell=4, mode 0.
  - Words 100, 110, 120, 130, with `tune_upd` 4 cycles apart.
  - `phase_clr` only with 100.
  - `done` 4 cycles after 130; `busy` then falls.
- Clamp and overflow: start=0xFFF0, stop=0xFFFF, step=0x20, dwell=1.
  - Words 0xFFF0 then 0xFFFF (carry clamped), then `done`.
  - Then stop=90, start=100 → only 100 is issued, then `done`.
- Continuous: start=10, stop=30, step=10, dwell=2, mode 1.
  - Sequence 10, 20, 30, 10, …; `phase_clr` with every 10.
  - `abort` mid-dwell → `busy` low next cycle, no `done`, `tune_word` unchanged.
- Ping-pong (macro defined): start=10, stop=40, step=15, dwell=3.
  - Sequence 10, 25, 40, 25, 10, 25, …
  - `sweep_dir` 1 from the first 25 after 40 through the following 10.
  - Without the macro the same stimulus gives 10, 25, 40, 10, …
- Shadowing and contention:
  - Rewrite step during a sweep → the current sweep is unaffected and the next sweep uses the new step.
  - `start` while busy → ignored.
  - `start` with `abort` in the same cycle → stays IDLE.
